vectored_interrupt_controller: RTL and testbench

- Parametrised, multi-source interrupt controller for the 16-bit core.
- Combines per-source flag bits (TIFR-style), per-source mask bits (TIMSK-style) and the SREG global-enable bit.
- Selects one pending source by priority, computes its vector, and holds `irq` until the CPU acknowledges it.
- Tracks the in-service source until the CPU executes the return-from-interrupt, so only one interrupt is in service at a time.

---
 rtl/vectored_interrupt_controller.sv | 178 +++++++++++++++++
 tb/tb_vectored_interrupt_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vectored_interrupt_controller.sv
// Purpose : multi-source vectored interrupt controller (flag & mask & global enable -> priority pick -> vector)
// Latency : one clock from a pending source to irq; arbitration resumes the cycle after iret
// Backpress: irq is held with a stable vector/irq_id until ack; a request whose source drops before ack is withdrawn
//
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   src_flag, src_mask  - per-source raised flag (level) and enable (1 = unmasked)
//   global_en           - SREG I bit, gates every source
//   ack, iret           - CPU took the vector / returned from the handler (1-cycle pulses)
//   irq                 - interrupt request to the CPU
//   vector, irq_id      - vector address and source index of the current or last request
//   in_service          - an acknowledged interrupt has not yet returned
//
// Build option: define RR_PRIORITY_EN for round-robin arbitration starting after the
// last acknowledged source; otherwise index 0 always wins.

module vectored_interrupt_controller #(
    parameter int NUM_SRC       = 8,
    parameter int ID_WIDTH      = 3,
    parameter int I_ADDR_WIDTH  = 10,
    parameter int VECTOR_BASE   = 1,
    parameter int VECTOR_STRIDE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SRC-1:0]      src_flag,
    input  logic [NUM_SRC-1:0]      src_mask,
    input  logic                    global_en,
    input  logic                    ack,
    input  logic                    iret,
    output logic                    irq,
    output logic [I_ADDR_WIDTH-1:0] vector,
    output logic [ID_WIDTH-1:0]     irq_id,
    output logic                    in_service
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    irq_q, irq_d;
    logic [I_ADDR_WIDTH-1:0] vector_q, vector_d;
    logic [ID_WIDTH-1:0]     irq_id_q, irq_id_d;
    logic                    in_service_q, in_service_d;

    logic [NUM_SRC-1:0]      pend;
    logic                    pend_cur;
    logic [ID_WIDTH-1:0]     sel_id;
    logic [I_ADDR_WIDTH-1:0] sel_vec;

    assign pend = src_flag & src_mask & {NUM_SRC{global_en}};

    // Pending state of the source currently being requested; compared by index
    // value so the selector width never has to match the flag vector width.
    always_comb begin
        pend_cur = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (irq_id_q == ID_WIDTH'(i)) begin
                pend_cur = pend[i];
            end
        end
    end

`ifdef RR_PRIORITY_EN
    logic [ID_WIDTH-1:0] last_q, last_d;
    int                  rr_start;
    logic                rr_found;

    // Walk the sources starting one past the last acknowledged index, wrapping.
    always_comb begin
        sel_id   = '0;
        rr_found = 1'b0;
        rr_start = int'(last_q) + 1;
        if (rr_start >= NUM_SRC) begin
            rr_start = 0;
        end
        for (int off = 0; off < NUM_SRC; off++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!rr_found && pend[i] && (i == (rr_start + off) % NUM_SRC)) begin
                    sel_id   = ID_WIDTH'(i);
                    rr_found = 1'b1;
                end
            end
        end
    end
`else
    // Fixed priority: scan downwards so the lowest pending index is written last.
    always_comb begin
        sel_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_id = ID_WIDTH'(i);
            end
        end
    end
`endif

    // Truncating arithmetic at vector width; overflow wraps silently.
    assign sel_vec = I_ADDR_WIDTH'(VECTOR_BASE)
                   + I_ADDR_WIDTH'(sel_id) * I_ADDR_WIDTH'(VECTOR_STRIDE);

    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        vector_d     = vector_q;
        irq_id_d     = irq_id_q;
        in_service_d = in_service_q;
`ifdef RR_PRIORITY_EN
        last_d       = last_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pend != '0) begin
                    irq_d    = 1'b1;
                    irq_id_d = sel_id;
                    vector_d = sel_vec;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                // ack wins over a same-cycle withdrawal; no re-arbitration here.
                if (ack) begin
                    irq_d        = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = ST_SVC;
`ifdef RR_PRIORITY_EN
                    last_d       = irq_id_q;
`endif
                end else if (!pend_cur) begin
                    irq_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_SVC: begin
                if (iret) begin
                    in_service_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                irq_d        = 1'b0;
                in_service_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            irq_q        <= 1'b0;
            vector_q     <= '0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
`ifdef RR_PRIORITY_EN
            last_q       <= ID_WIDTH'(NUM_SRC - 1);
`endif
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            vector_q     <= vector_d;
            irq_id_q     <= irq_id_d;
            in_service_q <= in_service_d;
`ifdef RR_PRIORITY_EN
            last_q       <= last_d;
`endif
        end
    end

    assign irq        = irq_q;
    assign vector     = vector_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Bench for vectored_interrupt_controller: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level reference model.

module tb_vectored_interrupt_controller;

    localparam int N   = 8;
    localparam int IDW = 3;
    localparam int AW  = 10;
    localparam int VB  = 1;
    localparam int VS  = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  src_flag;
    logic [N-1:0]  src_mask;
    logic          global_en;
    logic          ack;
    logic          iret;
    logic          irq;
    logic [AW-1:0] vector;
    logic [IDW-1:0] irq_id;
    logic          in_service;

    int n_cmp  = 0;
    int n_fail = 0;

    vectored_interrupt_controller #(
        .NUM_SRC(N), .ID_WIDTH(IDW), .I_ADDR_WIDTH(AW),
        .VECTOR_BASE(VB), .VECTOR_STRIDE(VS)
    ) dut (
        .clk(clk), .reset(reset), .src_flag(src_flag), .src_mask(src_mask),
        .global_en(global_en), .ack(ack), .iret(iret), .irq(irq),
        .vector(vector), .irq_id(irq_id), .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the controller as "what the CPU sees": a request is outstanding,
    // a handler is running, or neither.
    bit m_irq, m_svc;
    int m_id, m_vec, m_last;

    function automatic int pick(input logic [N-1:0] p, input int last);
        int start;
`ifdef RR_PRIORITY_EN
        start = (last + 1) % N;
`else
        start = 0 * last;
`endif
        for (int off = 0; off < N; off++) begin
            if (p[(start + off) % N]) return (start + off) % N;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] p;
        p = src_flag & src_mask & (global_en ? {N{1'b1}} : {N{1'b0}});
        if (reset) begin
            m_irq = 0; m_svc = 0; m_id = 0; m_vec = 0; m_last = N - 1;
        end else if (m_svc) begin
            if (iret) m_svc = 0;
        end else if (m_irq) begin
            if (ack) begin
                m_irq = 0; m_svc = 1; m_last = m_id;
            end else if (!p[m_id]) begin
                m_irq = 0;
            end
        end else if (p != 0) begin
            m_id  = pick(p, m_last);
            m_vec = (VB + m_id * VS) % (1 << AW);
            m_irq = 1;
        end
        #1;
        check("model_irq", int'(irq), int'(m_irq));
        check("model_vector", int'(vector), m_vec);
        check("model_irq_id", int'(irq_id), m_id);
        check("model_in_service", int'(in_service), int'(m_svc));
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_irq"}, int'(irq), 0);
        check({tag, "_vector"}, int'(vector), 0);
        check({tag, "_irq_id"}, int'(irq_id), 0);
        check({tag, "_in_service"}, int'(in_service), 0);
    endtask

    int exp_rr_id;

    initial begin
        reset = 1'b1; src_flag = '0; src_mask = '0; global_en = 1'b0;
        ack = 1'b0; iret = 1'b0;
        cyc();
        check_zero("reset");
        reset = 1'b0;

        // 1: single source
        global_en = 1'b1; src_mask = 8'h04; src_flag = 8'h04;
        cyc();
        check("t1_irq", int'(irq), 1);
        check("t1_id", int'(irq_id), 2);
        check("t1_vec", int'(vector), 3);
        ack = 1'b1; cyc(); ack = 1'b0;
        check("t1_ack_irq", int'(irq), 0);
        check("t1_ack_svc", int'(in_service), 1);
        src_flag = '0; iret = 1'b1; cyc(); iret = 1'b0;
        check("t1_iret_svc", int'(in_service), 0);

        // 2: priority and round-robin
        do_reset();
        src_flag = 8'h0A; src_mask = 8'hFF;
        cyc();
        check("t2_id", int'(irq_id), 1);
        check("t2_vec", int'(vector), 2);
        ack = 1'b1; cyc(); ack = 1'b0;
        iret = 1'b1; cyc(); iret = 1'b0;
        check("t2_gap_irq", int'(irq), 0);
        cyc();
`ifdef RR_PRIORITY_EN
        exp_rr_id = 3;
`else
        exp_rr_id = 1;
`endif
        check("t2_again_irq", int'(irq), 1);
        check("t2_again_id", int'(irq_id), exp_rr_id);
        check("t2_again_vec", int'(vector), exp_rr_id + 1);
        src_flag = '0; cyc();

        // 3: gating
        do_reset();
        src_flag = 8'h01; global_en = 1'b0; src_mask = 8'hFF;
        cyc(); cyc();
        check("t3_gen0_irq", int'(irq), 0);
        global_en = 1'b1; src_mask = 8'h00;
        cyc(); cyc();
        check("t3_mask0_irq", int'(irq), 0);
        src_mask = 8'h01;
        cyc();
        check("t3_irq", int'(irq), 1);
        check("t3_vec", int'(vector), 1);
        src_flag = '0; cyc();

        // 4: withdrawal, then ack beating withdrawal
        do_reset();
        src_mask = 8'hFF; src_flag = 8'h20;
        cyc();
        check("t4_id", int'(irq_id), 5);
        check("t4_vec", int'(vector), 6);
        src_flag = '0;
        cyc();
        check("t4_wd_irq", int'(irq), 0);
        check("t4_wd_vec", int'(vector), 6);
        check("t4_wd_id", int'(irq_id), 5);
        check("t4_wd_svc", int'(in_service), 0);
        cyc();
        check("t4_idle_irq", int'(irq), 0);
        src_flag = 8'h20; cyc();
        check("t4_re_irq", int'(irq), 1);
        src_flag = '0; ack = 1'b1; cyc(); ack = 1'b0;
        check("t4_race_irq", int'(irq), 0);
        check("t4_race_svc", int'(in_service), 1);

        // 5: no nesting, resume two cycles after iret
        src_flag = 8'h01;
        cyc(); cyc();
        check("t5_svc_irq", int'(irq), 0);
        check("t5_svc_svc", int'(in_service), 1);
        iret = 1'b1; cyc(); iret = 1'b0;
        check("t5_iret1_irq", int'(irq), 0);
        cyc();
        check("t5_iret2_irq", int'(irq), 1);
        check("t5_id", int'(irq_id), 0);
        check("t5_vec", int'(vector), 1);

        // 6: reset in REQ and in SVC
        reset = 1'b1; src_flag = '0; cyc(); reset = 1'b0;
        check_zero("t6_req");
        ack = 1'b1; cyc(); ack = 1'b0;
        check("t6_ack1_svc", int'(in_service), 0);
        src_flag = 8'h01; cyc();
        ack = 1'b1; cyc(); ack = 1'b0;
        check("t6_insvc", int'(in_service), 1);
        reset = 1'b1; src_flag = '0; cyc(); reset = 1'b0;
        check_zero("t6_svc");
        ack = 1'b1; cyc(); ack = 1'b0;
        check("t6_ack2_svc", int'(in_service), 0);
        check("t6_ack2_irq", int'(irq), 0);

        // Randomized traffic; the model process checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 4) == 0) src_flag = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 9) == 0) src_mask = N'($urandom) | N'($urandom);
            global_en = ($urandom_range(0, 9) != 0);
            ack       = ($urandom_range(0, 2) == 0);
            iret      = ($urandom_range(0, 3) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            cyc();
        end
        reset = 1'b0; ack = 1'b0; iret = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
